dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares one single-ported synchronous data memory between two masters:
//   m0 = pipelined RV32I CPU MEM-stage port, m1 = loader/debug master.
//   Req/gnt handshake per master; read data is returned with rvalid after a
//   fixed memory latency. Sits between the CPU data port and the data RAM.
// PARAMETERS
//   AW      32  address width
//   DW      32  data width (byte enables are DW/8 bits wide)
//   RD_LAT  1   memory read latency in cycles, legal range 1..4
// PORTS
//   clk        in   1     clock
//   reset      in   1     asynchronous, active-high reset
//   m0_req     in   1     m0 access request; held until m0_gnt
//   m0_we      in   1     m0 write (1) / read (0)
//   m0_addr    in   AW    m0 byte address
//   m0_wdata   in   DW    m0 write data
//   m0_be      in   DW/8  m0 byte enables
//   m0_gnt     out  1     m0 request accepted this cycle
//   m0_rvalid  out  1     m0 read data valid (1-cycle pulse)
//   m0_rdata   out  DW    m0 read data
//   m1_*       same set as m0_* for master 1
//   m1_lock    in   1     m1 keeps ownership while high
//   mem_en     out  1     memory access strobe
//   mem_we     out  1     memory write
//   mem_addr   out  AW    memory address
//   mem_wdata  out  DW    memory write data
//   mem_be     out  DW/8  memory byte enables
//   mem_rdata  in   DW    memory read data, valid RD_LAT cycles after mem_en
//   busy       out  1     FSM not IDLE
//   owner      out  1     master of the current or last transfer
// BEHAVIOUR
//   - Reset: FSM=IDLE, wait counter=0, last_owner=1, owner=0. While reset
//     is high, all gnt, rvalid, mem_en, mem_we and busy are 0.
//   - FSM states: IDLE, RWAIT.
//     IDLE: if any req, pick a winner. mx_gnt=1 and mem_en=1 combinationally,
//       in the same cycle. mem_we/addr/wdata/be are muxed from the winner.
//       Write: completes in that cycle; stay in IDLE.
//       Read: go to RWAIT and load cnt=RD_LAT-1.
//     RWAIT: no grants; mem_en=0. When cnt==0, assert mx_rvalid for the
//       owner with mx_rdata=mem_rdata, then return to IDLE. Otherwise cnt--.
//   - Timing: back-to-back writes give 1 grant/cycle. A read occupies
//     1+RD_LAT cycles. No new grant is issued in the rvalid cycle.
//   - Arbitration in IDLE: if only one req is high, that master wins. If both
//     are high, the master != last_owner wins (round-robin).
//     last_owner/owner update on every grant.
//   - Lock: if owner==1 and m1_lock==1, only m1 may be granted; m0 waits.
//     m1_lock is ignored when owner==0.
//   - mx_rdata is 0 whenever mx_rvalid==0. The non-owner's rvalid stays 0.
//   - A req deasserted before gnt is legal and is simply dropped.
//   - Reset during RWAIT: the read is abandoned with no rvalid. The next
//     cycle after reset release is IDLE.
//   - Illegal RD_LAT (0 or >4) is a $error at elaboration.
// CONFIGURATION
//   ARB_CPU_PRIORITY_EN defined: fixed priority. m0 wins every tie; m1 is
//     served only when m0_req=0. m1_lock is still honoured.
//   Undefined (default): round-robin as above.
// TESTING
//   1 m0 read 0x100 alone, mem_rdata=0xDEADBEEF, RD_LAT=1 -> cycle0:
//     m0_gnt=1, mem_en=1, mem_we=0; cycle1: m0_rvalid=1, rdata=0xDEADBEEF,
//     busy=1; cycle2: busy=0.
//   2 Both masters request writes in the first cycle after reset -> m0 is
//     granted at c0, m1 at c1; mem_addr follows m0, then m1.
//   3 Both masters hold write reqs for 4 cycles -> grants alternate
//     m0,m1,m0,m1; with ARB_CPU_PRIORITY_EN: m0 x4, m1 never granted.
//   4 m1 granted with m1_lock=1 for 3 cycles while m0_req=1 -> m1 gets all 3
//     grants; m0_gnt at the first cycle after the lock drops.
//   5 m1 read with RD_LAT=3, reset asserted in the 2nd RWAIT cycle -> no
//     m1_rvalid; after release a m0 write is granted immediately.
//   6 m0 read followed by a m1 read request pending -> m1_gnt is issued only
//     in the cycle after m0_rvalid; the rdata of each read reaches its own
//     master only.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// One master's request/response port into the data-memory arbiter.
// The master modport is the requesting side; the slave modport is the arbiter side.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter (m0 = CPU MEM stage, m1 = loader/debug) for one synchronous data RAM.
// Define ARB_CPU_PRIORITY_EN for fixed m0 priority; otherwise ties are round-robin.
//
// state    | meaning
// S_IDLE   | grants issued combinationally; writes complete here
// S_RWAIT  | read in flight; rvalid to owner when cnt reaches 0
module dmem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   m0,
  dmem_port_arbiter_if.slave   m1,
  input  logic                 m1_lock,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic [DW/8-1:0]      mem_be,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic                 owner
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dmem_port_arbiter: RD_LAT must be in 1..4");
  end

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic {S_IDLE, S_RWAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       last_owner;
  logic       m0_elig, m1_elig;
  logic       win, win_we, grant, rd_done;

  // A locked m1 owner shuts m0 out; lock means nothing once m0 owns the RAM.
  always_comb begin
    m0_elig = m0.req & ~(owner & m1_lock);
    m1_elig = m1.req;
`ifdef ARB_CPU_PRIORITY_EN
    win = ~m0_elig;
`else
    if (m0_elig && m1_elig)
      win = ~last_owner;
    else
      win = ~m0_elig;
`endif
    grant  = (state == S_IDLE) & ~reset & (m0_elig | m1_elig);
    win_we = win ? m1.we : m0.we;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant && !win_we) begin
          state_nxt = S_RWAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_RWAIT: begin
        if (cnt == 2'd0) begin
          rd_done   = ~reset;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        owner      <= win;
        last_owner <= win;
      end
    end
  end

  // Memory command is driven only while a grant is live; idle cycles present zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    m0.gnt    = 1'b0;
    m1.gnt    = 1'b0;
    if (grant) begin
      mem_en = 1'b1;
      mem_we = win_we;
      if (win) begin
        m1.gnt    = 1'b1;
        mem_addr  = m1.addr;
        mem_wdata = m1.wdata;
        mem_be    = m1.be;
      end else begin
        m0.gnt    = 1'b1;
        mem_addr  = m0.addr;
        mem_wdata = m0.wdata;
        mem_be    = m0.be;
      end
    end
  end

  always_comb begin
    m0.rvalid = rd_done & ~owner;
    m1.rvalid = rd_done & owner;
    m0.rdata  = m0.rvalid ? mem_rdata : '0;
    m1.rdata  = m1.rvalid ? mem_rdata : '0;
    busy      = (state != S_IDLE);
  end

endmodule
